// File: rtl/finger_box_scanner.sv
// Raster-scans one binary frame and counts hand pixels inside NUM_BOX programmable
// boxes; at end of frame each count is thresholded into a per-finger open flag.
module finger_box_scanner #(
  parameter int IMG_W   = 120,
  parameter int IMG_H   = 160,
  parameter int COORD_W = 8,
  parameter int NUM_BOX = 5,
  parameter int CNT_W   = 10,
  parameter int IDX_W   = 3,
  parameter int NCNT_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               pixel_valid,
  input  logic               object_image,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic               cfg_en,
  input  logic [COORD_W-1:0] cfg_left,
  input  logic [COORD_W-1:0] cfg_right,
  input  logic [COORD_W-1:0] cfg_top,
  input  logic [COORD_W-1:0] cfg_bottom,
  input  logic [CNT_W-1:0]   cfg_thresh,
  output logic [NUM_BOX-1:0] finger_status,
  output logic [NCNT_W-1:0]  finger_count,
  output logic               status_valid,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_H - 1);

  state_t state, state_next;

  logic [COORD_W-1:0] row, col;
  logic [CNT_W-1:0]   count      [NUM_BOX];
  logic [CNT_W-1:0]   count_next [NUM_BOX];
  logic [NUM_BOX-1:0] box_en;
  logic [COORD_W-1:0] box_left   [NUM_BOX];
  logic [COORD_W-1:0] box_right  [NUM_BOX];
  logic [COORD_W-1:0] box_top    [NUM_BOX];
  logic [COORD_W-1:0] box_bottom [NUM_BOX];
  logic [CNT_W-1:0]   box_thresh [NUM_BOX];
  logic [NUM_BOX-1:0] status_next;
  logic [NCNT_W-1:0]  ones_next;
  logic               accept, last_pixel;

  // A restart pulse wins over any pixel presented in the same cycle.
  assign accept     = (state == SCAN) && pixel_valid && !frame_start;
  assign last_pixel = accept && (row == LAST_ROW) && (col == LAST_COL);

  assign busy         = (state == SCAN);
  assign status_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_start) state_next = SCAN;
      SCAN:    if (last_pixel)  state_next = DONE;
      DONE:    state_next = frame_start ? SCAN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Inverted boxes (left>right or top>bottom) fail the range test on their own.
  always_comb begin
    for (int i = 0; i < NUM_BOX; i++) begin
      count_next[i] = count[i];
      if (box_en[i] && object_image &&
          (col >= box_left[i]) && (col <= box_right[i]) &&
          (row >= box_top[i])  && (row <= box_bottom[i]) &&
          (count[i] != {CNT_W{1'b1}}))
        count_next[i] = count[i] + CNT_W'(1);
    end
  end

  always_comb begin
    ones_next = '0;
    for (int i = 0; i < NUM_BOX; i++) begin
      status_next[i] = box_en[i] && (count_next[i] > box_thresh[i]);
      ones_next      = ones_next + NCNT_W'(status_next[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row           <= '0;
      col           <= '0;
      finger_status <= '0;
      finger_count  <= '0;
      box_en        <= '0;
      for (int i = 0; i < NUM_BOX; i++) begin
        count[i]      <= '0;
        box_left[i]   <= '0;
        box_right[i]  <= '0;
        box_top[i]    <= '0;
        box_bottom[i] <= '0;
        box_thresh[i] <= '0;
      end
    end else begin
      if (frame_start) begin
        row <= '0;
        col <= '0;
        for (int i = 0; i < NUM_BOX; i++) count[i] <= '0;
      end else if (accept) begin
        for (int i = 0; i < NUM_BOX; i++) count[i] <= count_next[i];
        if (col == LAST_COL) begin
          col <= '0;
          row <= (row == LAST_ROW) ? '0 : row + COORD_W'(1);
        end else begin
          col <= col + COORD_W'(1);
        end
      end

      if (last_pixel) begin
        finger_status <= status_next;
        finger_count  <= ones_next;
      end

      // Geometry is frozen while scanning; out-of-range indices match no box.
      if (cfg_we && (state != SCAN)) begin
        for (int i = 0; i < NUM_BOX; i++) begin
          if (cfg_idx == IDX_W'(i)) begin
            box_en[i]     <= cfg_en;
            box_left[i]   <= cfg_left;
            box_right[i]  <= cfg_right;
            box_top[i]    <= cfg_top;
            box_bottom[i] <= cfg_bottom;
            box_thresh[i] <= cfg_thresh;
          end
        end
      end
    end
  end

endmodule
